// File: rtl/tag_array_ctrl.sv
// Tag-array SRAM controller: single-cycle lookups and writes to a 32-entry tag SRAM.
// Define TAG_CLEAR_EN to add the CLEAR sweep that invalidates every entry after reset and on flush.
module tag_array_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_index,
  input  logic [21:0] req_tag,
  input  logic        req_vbit,
  input  logic        flush,
  output logic        rsp_valid,
  output logic        rsp_hit,
  output logic [21:0] rsp_tag,
  output logic        rsp_vbit,
  output logic        CEB,
  output logic        WEB,
  output logic [4:0]  A,
  output logic [31:0] D,
  output logic [31:0] BWEB,
  input  logic [31:0] Q
);

  localparam logic [31:0] BWEB_ENTRY = 32'hFF80_0000;
  localparam logic [31:0] BWEB_NONE  = 32'hFFFF_FFFF;

  logic        sweep;
  logic [4:0]  sweep_idx;
  logic        acc_p0;
  logic        acc_rd_p0;
  logic [4:0]  a_hold_p1;
  logic [31:0] d_hold_p1;
  logic        vld_p1;
  logic [21:0] tag_p1;
  logic        unused_q;

`ifdef TAG_CLEAR_EN
  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Gated by rstn so the SRAM stays deselected while reset is held.
  assign sweep     = rstn & (state_q == ST_CLEAR);
  assign sweep_idx = cnt_q;
  assign req_ready = rstn & (state_q == ST_IDLE) & ~flush;
`else
  logic unused_flush;

  assign unused_flush = flush;
  assign sweep        = 1'b0;
  assign sweep_idx    = '0;
  assign req_ready    = rstn;
`endif

  assign acc_p0    = req_valid & req_ready;
  assign acc_rd_p0 = acc_p0 & ~req_write;

  always_comb begin
    CEB  = 1'b1;
    WEB  = 1'b1;
    BWEB = BWEB_NONE;
    A    = a_hold_p1;
    D    = d_hold_p1;
    if (sweep) begin
      CEB  = 1'b0;
      WEB  = 1'b0;
      BWEB = BWEB_ENTRY;
      A    = sweep_idx;
      D    = '0;
    end else if (acc_p0) begin
      CEB = 1'b0;
      WEB = ~req_write;
      A   = req_index;
      if (req_write) begin
        BWEB = BWEB_ENTRY;
        D    = {9'd0, req_vbit, req_tag};
      end
    end
  end

  // p0 -> p1: address/data hold and lookup tag aligned with the SRAM read latency
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_hold_p1 <= '0;
      d_hold_p1 <= '0;
      vld_p1    <= 1'b0;
      tag_p1    <= '0;
    end else begin
      a_hold_p1 <= A;
      d_hold_p1 <= D;
      vld_p1    <= acc_rd_p0;
      if (acc_rd_p0) tag_p1 <= req_tag;
    end
  end

  assign unused_q  = ^Q[31:23];
  assign rsp_valid = vld_p1;
  assign rsp_tag   = Q[21:0];
  assign rsp_vbit  = Q[22];
  assign rsp_hit   = vld_p1 & Q[22] & (Q[21:0] == tag_p1);

endmodule
